ram_banked: RTL and testbench

RAM_BANKED -- requirements
Module: ram_banked

---
 rtl/ram_banked.sv | 123 ++++++++++++
 tb/tb_ram_banked.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_banked.sv
// Dual-port banked RAM: registered per-bank read data, port A wins write/write conflicts.
// Optional even-parity storage and perr_a/perr_b outputs when RAM_BANKED_PARITY_EN is defined.
module ram_banked #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int BANK_BITS  = 1,
  parameter int READ_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  en_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  collision
`ifdef RAM_BANKED_PARITY_EN
  ,
  output logic                  perr_a,
  output logic                  perr_b
`endif
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int IDX_W     = ADDR_WIDTH - BANK_BITS;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
`ifdef RAM_BANKED_PARITY_EN
  localparam int MEM_W     = DATA_WIDTH + 1;
`else
  localparam int MEM_W     = DATA_WIDTH;
`endif

  function automatic logic [MEM_W-1:0] enc_word(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_BANKED_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0] mem [NUM_BANKS][DEPTH];

  logic [SEL_W-1:0] bank_a, bank_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             same_addr, wr_a, wr_b_req, wr_b;
  logic [MEM_W-1:0] rd_a_nxt, rd_b_nxt;

  assign bank_a    = SEL_W'(addr_a >> IDX_W);
  assign bank_b    = SEL_W'(addr_b >> IDX_W);
  assign idx_a     = addr_a[IDX_W-1:0];
  assign idx_b     = addr_b[IDX_W-1:0];
  assign same_addr = (addr_a == addr_b);
  assign wr_a      = en_a & we_a & ~rst;
  assign wr_b_req  = en_b & we_b & ~rst;
  // Port B's write is dropped when port A writes the same word.
  assign wr_b      = wr_b_req & ~(wr_a & same_addr);

  // A port only sees its own new data; the other port always reads the pre-write word.
  always_comb begin
    rd_a_nxt = mem[bank_a][idx_a];
    rd_b_nxt = mem[bank_b][idx_b];
    if (READ_MODE == 1 && wr_a) rd_a_nxt = enc_word(data_a);
    if (READ_MODE == 1 && wr_b) rd_b_nxt = enc_word(data_b);
  end

  always_ff @(posedge clk) begin
    if (wr_b) mem[bank_b][idx_b] <= enc_word(data_b);
    if (wr_a) mem[bank_a][idx_a] <= enc_word(data_a);
  end

  // Stage p0: per-bank read registers plus the registered bank select and valid.
  logic [MEM_W-1:0] rd_a_p0 [NUM_BANKS];
  logic [MEM_W-1:0] rd_b_p0 [NUM_BANKS];
  logic [SEL_W-1:0] bank_a_p0, bank_b_p0;
  logic             vld_a_p0, vld_b_p0, coll_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_p0  <= 1'b0;
      vld_b_p0  <= 1'b0;
      coll_p0   <= 1'b0;
      bank_a_p0 <= '0;
      bank_b_p0 <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_a_p0[b] <= '0;
        rd_b_p0[b] <= '0;
      end
    end else begin
      vld_a_p0 <= en_a;
      vld_b_p0 <= en_b;
      coll_p0  <= wr_a & wr_b_req & same_addr;
      if (en_a) begin
        rd_a_p0[bank_a] <= rd_a_nxt;
        bank_a_p0       <= bank_a;
      end
      if (en_b) begin
        rd_b_p0[bank_b] <= rd_b_nxt;
        bank_b_p0       <= bank_b;
      end
    end
  end

  assign q_a       = rd_a_p0[bank_a_p0][DATA_WIDTH-1:0];
  assign q_b       = rd_b_p0[bank_b_p0][DATA_WIDTH-1:0];
  assign valid_a   = vld_a_p0;
  assign valid_b   = vld_b_p0;
  assign collision = coll_p0;

`ifdef RAM_BANKED_PARITY_EN
  // Stored word carries its even-parity bit, so a clean word XORs to zero.
  assign perr_a = ^rd_a_p0[bank_a_p0];
  assign perr_b = ^rd_b_p0[bank_b_p0];
`endif

endmodule

// File: tb/tb_ram_banked.sv
// Bench for ram_banked: READ_MODE=0 and READ_MODE=1 instances on shared inputs,
// directed scenarios plus randomized traffic against an array-based reference model.
module tb_ram_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [15:0] q_a0, q_b0, q_a1, q_b1;
  logic        va0, vb0, va1, vb1, c0, c1;
`ifdef RAM_BANKED_PARITY_EN
  logic        pa0, pb0, pa1, pb1;
`endif

  ram_banked #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BANK_BITS(1), .READ_MODE(0)) dut (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a0), .q_b(q_b0), .valid_a(va0), .valid_b(vb0), .collision(c0)
`ifdef RAM_BANKED_PARITY_EN
    , .perr_a(pa0), .perr_b(pb0)
`endif
  );

  ram_banked #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BANK_BITS(1), .READ_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a1), .q_b(q_b1), .valid_a(va1), .valid_b(vb1), .collision(c1)
`ifdef RAM_BANKED_PARITY_EN
    , .perr_a(pa1), .perr_b(pb1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ref_mem [1024];
  logic [15:0] e_qa0 = '0, e_qa1 = '0, e_qb0 = '0, e_qb1 = '0;
  logic        e_va = 1'b0, e_vb = 1'b0, e_coll = 1'b0;

  // One clocked access on both ports; updates the reference model and expectations.
  task automatic step(input logic ea, input logic wa, input logic [9:0] aa, input logic [15:0] da,
                      input logic eb, input logic wb, input logic [9:0] ab, input logic [15:0] db);
    logic [15:0] old_a, old_b;
    logic        a_wr, b_wr, coll;
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    old_a = ref_mem[aa];
    old_b = ref_mem[ab];
    a_wr  = ea & wa;
    b_wr  = eb & wb;
    coll  = a_wr & b_wr & (aa == ab);
    if (ea) begin e_qa0 = old_a; e_qa1 = a_wr ? da : old_a; end
    if (eb) begin e_qb0 = old_b; e_qb1 = (b_wr && !coll) ? db : old_b; end
    e_va = ea; e_vb = eb; e_coll = coll;
    if (b_wr && !coll) ref_mem[ab] = db;
    if (a_wr) ref_mem[aa] = da;
    @(posedge clk);
    #1;
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({q_a0, q_b0, q_a1, q_b1} !== 64'h0) begin
      n_err++; $display("FAIL reset_q: got %h want 0", {q_a0, q_b0, q_a1, q_b1});
    end
    n_vec++;
    if ({va0, vb0, va1, vb1, c0, c1} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 000000", {va0, vb0, va1, vb1, c0, c1});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({va0, vb0, c0} !== 3'b0) begin
      n_err++; $display("FAIL reset_release: got %b want 000", {va0, vb0, c0});
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b1, 10'(i), 16'($urandom), 1'b1, 1'b1, 10'(i + 512), 16'($urandom));
      if (i % 128 == 0) begin
        n_vec++;
        if ({va0, vb0} !== 2'b11) begin
          n_err++; $display("FAIL preload_valid: got %b want 11", {va0, vb0});
        end
      end
    end
  endtask

  task automatic test_write_read_cross();
    step(1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h000, 16'h0);
    n_vec++;
    if (vb0 !== 1'b0) begin n_err++; $display("FAIL xrd_idle_vb: got %b want 0", vb0); end
    step(1'b0, 1'b0, 10'h000, 16'h0, 1'b1, 1'b0, 10'h005, 16'h0);
    n_vec++;
    if ({vb0, q_b0} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL xrd_q_b: got %b/%h want 1/1234", vb0, q_b0);
    end
    n_vec++;
    if (q_b1 !== 16'h1234) begin n_err++; $display("FAIL xrd_q_b_m1: got %h want 1234", q_b1); end
    step(1'b0, 1'b0, 10'h000, 16'h0, 1'b0, 1'b0, 10'h3FF, 16'h0);
    n_vec++;
    if ({vb0, q_b0} !== {1'b0, 16'h1234}) begin
      n_err++; $display("FAIL xrd_hold: got %b/%h want 0/1234", vb0, q_b0);
    end
  endtask

  task automatic test_bank_mux();
    step(1'b1, 1'b1, 10'h005, 16'hAAAA, 1'b0, 1'b0, 10'h0, 16'h0);
    step(1'b1, 1'b1, 10'h205, 16'h5555, 1'b0, 1'b0, 10'h0, 16'h0);
    step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if (q_a0 !== 16'hAAAA) begin n_err++; $display("FAIL bank_rd0: got %h want aaaa", q_a0); end
    step(1'b1, 1'b0, 10'h205, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if (q_a0 !== 16'h5555) begin n_err++; $display("FAIL bank_rd1: got %h want 5555", q_a0); end
    step(1'b0, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if ({va0, q_a0} !== {1'b0, 16'h5555}) begin
      n_err++; $display("FAIL bank_hold: got %b/%h want 0/5555", va0, q_a0);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b1, 10'h0F0, 16'h1111, 1'b1, 1'b1, 10'h0F0, 16'h2222);
    n_vec++;
    if ({c0, c1} !== 2'b11) begin n_err++; $display("FAIL coll_pulse: got %b want 11", {c0, c1}); end
    step(1'b0, 1'b0, 10'h0F0, 16'h0, 1'b0, 1'b0, 10'h0F0, 16'h0);
    n_vec++;
    if ({c0, c1} !== 2'b00) begin n_err++; $display("FAIL coll_clear: got %b want 00", {c0, c1}); end
    step(1'b1, 1'b0, 10'h0F0, 16'h0, 1'b1, 1'b0, 10'h0F0, 16'h0);
    n_vec++;
    if ({q_a0, q_b0, q_b1} !== {16'h1111, 16'h1111, 16'h1111}) begin
      n_err++; $display("FAIL coll_winner: got %h %h %h want 1111", q_a0, q_b0, q_b1);
    end
  endtask

  task automatic test_read_during_write();
    step(1'b1, 1'b1, 10'h123, 16'h0001, 1'b0, 1'b0, 10'h0, 16'h0);
    step(1'b1, 1'b1, 10'h123, 16'h00FF, 1'b1, 1'b0, 10'h123, 16'h0);
    n_vec++;
    if (q_a0 !== 16'h0001) begin n_err++; $display("FAIL rdw_old: got %h want 0001", q_a0); end
    n_vec++;
    if (q_a1 !== 16'h00FF) begin n_err++; $display("FAIL rdw_new: got %h want 00ff", q_a1); end
    n_vec++;
    if ({q_b0, q_b1, c0} !== {16'h0001, 16'h0001, 1'b0}) begin
      n_err++; $display("FAIL rdw_cross: got %h %h %b want 0001 0001 0", q_b0, q_b1, c0);
    end
    step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h123, 16'h0);
    n_vec++;
    if (q_b0 !== 16'h00FF) begin n_err++; $display("FAIL rdw_after: got %h want 00ff", q_b0); end
  endtask

  task automatic test_random();
    logic [9:0] pool [4];
    pool[0] = 10'h005; pool[1] = 10'h205; pool[2] = 10'h0F0; pool[3] = 10'h3FF;
    for (int i = 0; i < 400; i++) begin
      logic        ea, wa, eb, wb;
      logic [9:0]  aa, ab;
      ea = ($urandom % 4) != 0;  wa = 1'($urandom);
      eb = ($urandom % 4) != 0;  wb = 1'($urandom);
      aa = ($urandom % 3 == 0) ? pool[$urandom % 4] : 10'($urandom);
      ab = ($urandom % 3 == 0) ? pool[$urandom % 4] : 10'($urandom);
      if (ea && wa && eb && wb && aa == ab) wb = 1'b0;
      step(ea, wa, aa, 16'($urandom), eb, wb, ab, 16'($urandom));
      n_vec++;
      if ({va0, vb0, va1, vb1, c0, c1} !== {e_va, e_vb, e_va, e_vb, e_coll, e_coll}) begin
        n_err++;
        $display("FAIL rnd_ctl[%0d]: got %b want %b", i, {va0, vb0, va1, vb1, c0, c1},
                 {e_va, e_vb, e_va, e_vb, e_coll, e_coll});
      end
      n_vec++;
      if ({q_a0, q_b0} !== {e_qa0, e_qb0}) begin
        n_err++; $display("FAIL rnd_q_m0[%0d]: got %h %h want %h %h", i, q_a0, q_b0, e_qa0, e_qb0);
      end
      n_vec++;
      if ({q_a1, q_b1} !== {e_qa1, e_qb1}) begin
        n_err++; $display("FAIL rnd_q_m1[%0d]: got %h %h want %h %h", i, q_a1, q_b1, e_qa1, e_qb1);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h0, 16'h0);
    step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if ({va0, q_a0} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL rstmid_pre: got %b/%h want 1/1234", va0, q_a0);
    end
    en_a = 1'b1; we_a = 1'b0; addr_a = 10'h005;
    en_b = 1'b1; we_b = 1'b1; addr_b = 10'h005; data_b = 16'hDEAD;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({q_a0, q_a1, va0, va1, vb0, c0} !== 36'h0) begin
      n_err++; $display("FAIL rstmid_async: got %h %h %b want 0", q_a0, q_a1, {va0, va1, vb0, c0});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    en_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({va0, va1, vb0, q_a0} !== {3'b000, 16'h0}) begin
      n_err++; $display("FAIL rstmid_novalid: got %b/%h want 000/0000", {va0, va1, vb0}, q_a0);
    end
    e_qa0 = '0; e_qa1 = '0; e_qb0 = '0; e_qb1 = '0;
    step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if ({va0, q_a0} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL rstmid_retained: got %b/%h want 1/1234", va0, q_a0);
    end
  endtask

`ifdef RAM_BANKED_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b1, 10'h007, 16'h0F0F, 1'b0, 1'b0, 10'h0, 16'h0);
    dut.mem[0][7][0] = ~dut.mem[0][7][0];
    step(1'b1, 1'b0, 10'h007, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if (pa0 !== 1'b1) begin n_err++; $display("FAIL perr_flip: got %b want 1", pa0); end
    step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    n_vec++;
    if (pa0 !== 1'b0) begin n_err++; $display("FAIL perr_clean: got %b want 0", pa0); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_write_read_cross();
    test_bank_mux();
    test_collision();
    test_read_during_write();
    test_random();
    test_reset_mid_read();
`ifdef RAM_BANKED_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
